// File: rtl/wash_panel.sv
`default_nettype none
// ============================================================================
// Module      : wash_panel
// Description : Front-panel controller for a coin-operated washing machine.
//               It debounces the coin sensor and the mode and pause buttons,
//               keeps the coin credit, and runs the wash cycle through its
//               phases. It hands start, mode and pause to the wash
//               controller.
// Ports       : clock, rst             - system clock, synchronous active-high
//                                         reset
//               coin_raw, mode_btn,
//               pause_btn              - raw (bouncing) panel inputs
//               wash_done, click_*     - controller status flags
//                                         (rising edges are used)
//               coin_in                - start request, high for 2 cycles
//               double_wash            - selected wash mode
//               timer_pause            - spin pause request
//               credit                 - stored coins (0..3)
//               phase                  - current wash phase
//               busy, done_led         - cycle status indicators
// Revision    : 1.0 - initial release
// ============================================================================
module wash_panel #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PRICE_SINGLE    = 1,
   parameter int PRICE_DOUBLE    = 2
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       coin_raw,
   input  logic       mode_btn,
   input  logic       pause_btn,
   input  logic       wash_done,
   input  logic       click_fill,
   input  logic       click_wash_1,
   input  logic       click_rinse_1,
   input  logic       click_wash_2,
   input  logic       click_rinse_2,
   input  logic       click_spin,
   output logic       coin_in,
   output logic       double_wash,
   output logic       timer_pause,
   output logic [1:0] credit,
   output logic [2:0] phase,
   output logic       busy,
   output logic       done_led
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0] PRICE_S = 2'(PRICE_SINGLE);
   localparam logic [1:0] PRICE_D = 2'(PRICE_DOUBLE);

   // Panel input indices
   localparam int IN_COIN  = 0;
   localparam int IN_MODE  = 1;
   localparam int IN_PAUSE = 2;

   // Controller flag indices
   localparam int CK_FILL   = 0;
   localparam int CK_WASH1  = 1;
   localparam int CK_RINSE1 = 2;
   localparam int CK_WASH2  = 3;
   localparam int CK_RINSE2 = 4;
   localparam int CK_SPIN   = 5;
   localparam int CK_DONE   = 6;

   localparam logic [2:0] ST_SELECT  = 3'd0;
   localparam logic [2:0] ST_ARMED   = 3'd1;
   localparam logic [2:0] ST_RUNNING = 3'd2;
   localparam logic [2:0] ST_PAUSED  = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [2:0] PH_NONE   = 3'd0;
   localparam logic [2:0] PH_FILL   = 3'd1;
   localparam logic [2:0] PH_WASH1  = 3'd2;
   localparam logic [2:0] PH_RINSE1 = 3'd3;
   localparam logic [2:0] PH_WASH2  = 3'd4;
   localparam logic [2:0] PH_RINSE2 = 3'd5;
   localparam logic [2:0] PH_SPIN   = 3'd6;

   // ------------------------------------------------------------------------
   // Debouncers: the accepted level follows the raw level only after the raw
   // level has disagreed with it for DEBOUNCE_CYCLES consecutive samples.
   // The rise event is registered from the accepted level and its delayed
   // copy, giving DEBOUNCE_CYCLES+1 cycles from the raw edge to the event.
   // ------------------------------------------------------------------------
   logic [2:0] raw_in;
   logic [2:0] db_level;
   logic [2:0] db_level_d;
   logic [2:0] db_ev;

   assign raw_in = {pause_btn, mode_btn, coin_raw};

   generate
      for (genvar i = 0; i < 3; i++) begin : g_debounce
         logic [CNT_W-1:0] cnt;

         always_ff @(posedge clock) begin
            if (rst) begin
               cnt           <= '0;
               db_level[i]   <= 1'b0;
               db_level_d[i] <= 1'b0;
               db_ev[i]      <= 1'b0;
            end else begin
               if (raw_in[i] != db_level[i]) begin
                  if (cnt == CNT_LAST) begin
                     db_level[i] <= raw_in[i];
                     cnt         <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  // any sample agreeing with the accepted level restarts
                  cnt <= '0;
               end
               db_level_d[i] <= db_level[i];
               db_ev[i]      <= db_level[i] & ~db_level_d[i];
            end
         end
      end
   endgenerate

   logic coin_ev;
   logic mode_ev;
   logic pause_ev;

   assign coin_ev  = db_ev[IN_COIN];
   assign mode_ev  = db_ev[IN_MODE];
   assign pause_ev = db_ev[IN_PAUSE];

   // ------------------------------------------------------------------------
   // Controller flag edge detectors (registered, one cycle delay)
   // ------------------------------------------------------------------------
   logic [6:0] flag_in;
   logic [6:0] flag_hist;
   logic [6:0] flag_edge;

   assign flag_in = {wash_done, click_spin, click_rinse_2, click_wash_2,
                     click_rinse_1, click_wash_1, click_fill};

   always_ff @(posedge clock) begin
      if (rst) begin
         flag_hist <= '0;
         flag_edge <= '0;
      end else begin
         flag_hist <= flag_in;
         flag_edge <= flag_in & ~flag_hist;
      end
   end

   // ------------------------------------------------------------------------
   // Panel state machine
   // ------------------------------------------------------------------------
   logic [2:0] state;
   logic [2:0] state_n;
   logic [2:0] phase_n;
   logic [1:0] credit_n;
   logic       dw_n;
   logic       arm_cnt;
   logic       arm_n;
   logic       coin_in_n;
   logic       busy_n;
   logic       timer_pause_n;
   logic       done_led_n;

   logic [1:0] price;
   logic       can_arm;
   logic [1:0] credit_base;
   logic [2:0] credit_sum;

   assign price   = double_wash ? PRICE_D : PRICE_S;
   assign can_arm = (state == ST_SELECT) && (credit >= price);

   // Credit update: price is taken when arming, then a coin in the same
   // cycle is added on top, saturating at 3.
   always_comb begin
      credit_base = can_arm ? (credit - price) : credit;
      credit_sum  = {1'b0, credit_base} + 3'd1;
      credit_n    = credit_base;
      if (coin_ev) begin
         credit_n = credit_sum[2] ? 2'd3 : credit_sum[1:0];
      end
   end

   // State register (all outputs are registered here)
   always_ff @(posedge clock) begin
      if (rst) begin
         state       <= ST_SELECT;
         phase       <= PH_NONE;
         credit      <= 2'd0;
         double_wash <= 1'b0;
         arm_cnt     <= 1'b0;
         coin_in     <= 1'b0;
         busy        <= 1'b0;
         timer_pause <= 1'b0;
         done_led    <= 1'b0;
      end else begin
         state       <= state_n;
         phase       <= phase_n;
         credit      <= credit_n;
         double_wash <= dw_n;
         arm_cnt     <= arm_n;
         coin_in     <= coin_in_n;
         busy        <= busy_n;
         timer_pause <= timer_pause_n;
         done_led    <= done_led_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      phase_n = phase;
      dw_n    = double_wash;
      arm_n   = arm_cnt;
      case (state)
         ST_SELECT: begin
            if (mode_ev) begin
               dw_n = ~double_wash;
            end
            if (can_arm) begin
               state_n = ST_ARMED;
               arm_n   = 1'b0;
            end
         end
         ST_ARMED: begin
            // two cycles in ARMED give the two-cycle coin_in pulse
            if (!arm_cnt) begin
               arm_n = 1'b1;
            end else begin
               state_n = ST_RUNNING;
               phase_n = PH_FILL;
            end
         end
         ST_RUNNING: begin
            if (phase == PH_SPIN && flag_edge[CK_DONE]) begin
               state_n = ST_DONE;
               phase_n = PH_NONE;
            end else if (phase == PH_SPIN && pause_ev) begin
               state_n = ST_PAUSED;
            end else begin
               case (phase)
                  PH_FILL:   if (flag_edge[CK_FILL])   phase_n = PH_WASH1;
                  PH_WASH1:  if (flag_edge[CK_WASH1])  phase_n = PH_RINSE1;
                  PH_RINSE1: if (flag_edge[CK_RINSE1])
                                phase_n = double_wash ? PH_WASH2 : PH_SPIN;
                  PH_WASH2:  if (flag_edge[CK_WASH2])  phase_n = PH_RINSE2;
                  PH_RINSE2: if (flag_edge[CK_RINSE2]) phase_n = PH_SPIN;
                  // spin completion holds the phase; wash_done ends the cycle
                  PH_SPIN:   if (flag_edge[CK_SPIN])   phase_n = PH_SPIN;
                  default:   phase_n = phase;
               endcase
            end
         end
         ST_PAUSED: begin
            if (pause_ev) begin
               state_n = ST_RUNNING;
            end
         end
         ST_DONE: begin
            if (mode_ev) begin
               dw_n = ~double_wash;
            end
            if (coin_ev || mode_ev) begin
               state_n = ST_SELECT;
            end
         end
         default: begin
            state_n = ST_SELECT;
            phase_n = PH_NONE;
         end
      endcase
   end

   // Output logic, decoded from the next state so outputs are registered
   always_comb begin
      coin_in_n     = (state_n == ST_ARMED);
      busy_n        = (state_n == ST_ARMED) || (state_n == ST_RUNNING) ||
                      (state_n == ST_PAUSED);
      timer_pause_n = (state_n == ST_PAUSED);
      done_led_n    = (state_n == ST_DONE);
   end

endmodule
`default_nettype wire

// File: tb/tb_wash_panel.sv
`default_nettype none
// ============================================================================
// Module      : tb_wash_panel
// Description : Directed self-checking bench for wash_panel with
//               DEBOUNCE_CYCLES=4. It covers single and double wash, bounce
//               rejection, pause, credit saturation and carry, and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wash_panel;

   logic       clock;
   logic       rst;
   logic       coin_raw, mode_btn, pause_btn;
   logic       wash_done;
   logic       click_fill, click_wash_1, click_rinse_1;
   logic       click_wash_2, click_rinse_2, click_spin;
   logic       coin_in, double_wash, timer_pause, busy, done_led;
   logic [1:0] credit;
   logic [2:0] phase;

   int n_checks = 0;
   int n_fail   = 0;
   int n_cr1    = 0;   // cycles observed with credit == 1
   int n_coin   = 0;   // cycles observed with coin_in == 1
   int max_cr   = 0;   // largest credit observed

   localparam int B_COIN  = 0;
   localparam int B_MODE  = 1;
   localparam int B_PAUSE = 2;

   localparam int K_FILL   = 0;
   localparam int K_WASH1  = 1;
   localparam int K_RINSE1 = 2;
   localparam int K_WASH2  = 3;
   localparam int K_RINSE2 = 4;
   localparam int K_SPIN   = 5;
   localparam int K_DONE   = 6;

   wash_panel #(
      .DEBOUNCE_CYCLES(4),
      .PRICE_SINGLE   (1),
      .PRICE_DOUBLE   (2)
   ) dut (
      .clock        (clock),
      .rst          (rst),
      .coin_raw     (coin_raw),
      .mode_btn     (mode_btn),
      .pause_btn    (pause_btn),
      .wash_done    (wash_done),
      .click_fill   (click_fill),
      .click_wash_1 (click_wash_1),
      .click_rinse_1(click_rinse_1),
      .click_wash_2 (click_wash_2),
      .click_rinse_2(click_rinse_2),
      .click_spin   (click_spin),
      .coin_in      (coin_in),
      .double_wash  (double_wash),
      .timer_pause  (timer_pause),
      .credit       (credit),
      .phase        (phase),
      .busy         (busy),
      .done_led     (done_led)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance n cycles, sampling outputs on the falling edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         @(negedge clock);
         if (credit == 2'd1) n_cr1++;
         if (coin_in) n_coin++;
         if (int'(credit) > max_cr) max_cr = int'(credit);
      end
   endtask

   task automatic clear_counts();
      n_cr1  = 0;
      n_coin = 0;
      max_cr = 0;
   endtask

   task automatic set_button(input int which, input logic v);
      case (which)
         B_COIN:  coin_raw  = v;
         B_MODE:  mode_btn  = v;
         default: pause_btn = v;
      endcase
   endtask

   // Clean press: held 6 cycles (debounce is 4), released, then settled.
   task automatic press(input int which);
      set_button(which, 1'b1);
      step(6);
      set_button(which, 1'b0);
      step(10);
   endtask

   task automatic set_click(input int which, input logic v);
      case (which)
         K_FILL:   click_fill    = v;
         K_WASH1:  click_wash_1  = v;
         K_RINSE1: click_rinse_1 = v;
         K_WASH2:  click_wash_2  = v;
         K_RINSE2: click_rinse_2 = v;
         K_SPIN:   click_spin    = v;
         default:  wash_done     = v;
      endcase
   endtask

   task automatic click(input int which);
      set_click(which, 1'b1);
      step(1);
      set_click(which, 1'b0);
      step(4);
   endtask

   initial begin
      rst = 1'b1;
      coin_raw = 0; mode_btn = 0; pause_btn = 0; wash_done = 0;
      click_fill = 0; click_wash_1 = 0; click_rinse_1 = 0;
      click_wash_2 = 0; click_rinse_2 = 0; click_spin = 0;
      @(negedge clock);
      step(3);

      // ---- reset state ----
      check("rst_credit", credit, 0);
      check("rst_phase", phase, 0);
      check("rst_coin_in", coin_in, 0);
      check("rst_busy", busy, 0);
      check("rst_done_led", done_led, 0);
      rst = 1'b0;
      step(2);
      check("idle_busy", busy, 0);

      // ---- single wash ----
      clear_counts();
      press(B_COIN);
      check("sw_credit1_cycles", n_cr1, 1);
      check("sw_coin_in_cycles", n_coin, 2);
      check("sw_phase_fill", phase, 1);
      check("sw_busy", busy, 1);
      check("sw_credit_after_arm", credit, 0);
      click(K_WASH1);
      check("sw_wrong_click_ignored", phase, 1);
      click(K_FILL);
      check("sw_phase_wash1", phase, 2);
      click(K_WASH1);
      check("sw_phase_rinse1", phase, 3);
      click(K_RINSE1);
      check("sw_phase_spin", phase, 6);
      click(K_SPIN);
      check("sw_spin_holds", phase, 6);
      click(K_DONE);
      check("sw_done_led", done_led, 1);
      check("sw_done_phase", phase, 0);
      check("sw_done_busy", busy, 0);
      check("sw_done_credit", credit, 0);

      // ---- double wash ----
      press(B_MODE);
      check("dw_mode_set", double_wash, 1);
      check("dw_left_done", done_led, 0);
      clear_counts();
      press(B_COIN);
      check("dw_credit1", credit, 1);
      check("dw_still_select", busy, 0);
      press(B_COIN);
      check("dw_credit_after_arm", credit, 0);
      check("dw_busy", busy, 1);
      check("dw_coin_in_cycles", n_coin, 2);
      check("dw_phase_fill", phase, 1);
      click(K_FILL);
      check("dw_phase_wash1", phase, 2);
      press(B_PAUSE);
      check("dw_pause_ignored_tp", timer_pause, 0);
      check("dw_pause_ignored_ph", phase, 2);
      press(B_MODE);
      check("dw_mode_frozen", double_wash, 1);
      click(K_WASH1);
      check("dw_phase_rinse1", phase, 3);
      click(K_RINSE1);
      check("dw_phase_wash2", phase, 4);
      click(K_WASH2);
      check("dw_phase_rinse2", phase, 5);
      click(K_RINSE2);
      check("dw_phase_spin", phase, 6);
      press(B_PAUSE);
      check("dw_paused_tp", timer_pause, 1);
      check("dw_paused_busy", busy, 1);
      press(B_PAUSE);
      check("dw_resumed_tp", timer_pause, 0);
      check("dw_resumed_phase", phase, 6);
      click(K_DONE);
      check("dw_done_led", done_led, 1);

      // ---- bounce rejection ----
      for (int i = 0; i < 5; i++) begin
         coin_raw = 1'b1;
         step(2);
         coin_raw = 1'b0;
         step(2);
      end
      step(10);
      check("bounce_credit", credit, 0);
      check("bounce_still_done", done_led, 1);

      // ---- saturation and carry (double_wash = 1) ----
      press(B_COIN);
      check("sat_first_coin", credit, 1);
      press(B_COIN);
      check("sat_armed_credit", credit, 0);
      clear_counts();
      for (int i = 0; i < 4; i++) press(B_COIN);
      check("sat_credit_3", credit, 3);
      check("sat_max_credit", max_cr, 3);
      click(K_FILL);
      click(K_WASH1);
      click(K_RINSE1);
      click(K_WASH2);
      click(K_RINSE2);
      check("sat_phase_spin", phase, 6);
      click(K_DONE);
      check("sat_done_credit", credit, 3);
      press(B_COIN);
      check("carry_credit", credit, 1);
      check("carry_busy", busy, 1);

      // ---- reset while paused ----
      click(K_FILL);
      click(K_WASH1);
      click(K_RINSE1);
      click(K_WASH2);
      click(K_RINSE2);
      press(B_PAUSE);
      check("rp_paused", timer_pause, 1);
      rst = 1'b1;
      step(1);
      check("rp_credit", credit, 0);
      check("rp_phase", phase, 0);
      check("rp_timer_pause", timer_pause, 0);
      check("rp_busy", busy, 0);
      check("rp_double_wash", double_wash, 0);
      check("rp_coin_in", coin_in, 0);
      check("rp_done_led", done_led, 0);
      rst = 1'b0;
      clear_counts();
      click(K_FILL);
      click(K_RINSE1);
      step(10);
      check("rp_spurious_phase", phase, 0);
      check("rp_spurious_busy", busy, 0);
      check("rp_no_coin_in", n_coin, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
